// File: rtl/qsys_serial_target.sv
// Target end of the Qsys serial register link: deserialises 65-bit command
// frames, performs one Avalon-MM access, and serialises 32 bits back on sdo.
module qsys_serial_target #(
  parameter int unsigned address_size   = 8,
  parameter int unsigned timeout_cycles = 256
) (
  input  logic                    csi_MCLK_clk,
  input  logic                    rsi_MRST_reset_n,
  input  logic                    sdi,
  input  logic                    sle,
  output logic                    sdo,
  output logic                    srdy,
  output logic [address_size-1:0] avm_reg_address,
  output logic [31:0]             avm_reg_writedata,
  output logic [3:0]              avm_reg_byteenable,
  output logic                    avm_reg_write,
  output logic                    avm_reg_read,
  input  logic [31:0]             avm_reg_readdata,
  input  logic                    avm_reg_waitrequest,
  output logic                    frame_err,
  output logic                    bus_timeout
);

  localparam int unsigned WCW = $clog2(timeout_cycles + 1);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t                  state, state_n;
  logic [64:0]             rx, rx_n;
  logic [6:0]              len, len_n;
  logic [WCW-1:0]          wcnt, wcnt_n;
  logic [5:0]              k, k_n;
  logic [31:0]             tx, tx_n;
  logic                    sdo_n, srdy_n, rd_n, wr_n, ferr_n, bto_n;
  logic [address_size-1:0] addr_n;
  logic [31:0]             wdata_n;

  assign avm_reg_byteenable = 4'hF;

  always_ff @(posedge csi_MCLK_clk or negedge rsi_MRST_reset_n) begin
    if (!rsi_MRST_reset_n) begin
      state             <= IDLE;
      rx                <= '0;
      len               <= '0;
      wcnt              <= '0;
      k                 <= '0;
      tx                <= '0;
      sdo               <= 1'b0;
      srdy              <= 1'b0;
      avm_reg_address   <= '0;
      avm_reg_writedata <= '0;
      avm_reg_read      <= 1'b0;
      avm_reg_write     <= 1'b0;
      frame_err         <= 1'b0;
      bus_timeout       <= 1'b0;
    end else begin
      state             <= state_n;
      rx                <= rx_n;
      len               <= len_n;
      wcnt              <= wcnt_n;
      k                 <= k_n;
      tx                <= tx_n;
      sdo               <= sdo_n;
      srdy              <= srdy_n;
      avm_reg_address   <= addr_n;
      avm_reg_writedata <= wdata_n;
      avm_reg_read      <= rd_n;
      avm_reg_write     <= wr_n;
      frame_err         <= ferr_n;
      bus_timeout       <= bto_n;
    end
  end

  always_comb begin
    state_n = state;
    rx_n    = rx;
    len_n   = len;
    wcnt_n  = wcnt;
    k_n     = k;
    tx_n    = tx;
    sdo_n   = sdo;
    srdy_n  = srdy;
    addr_n  = avm_reg_address;
    wdata_n = avm_reg_writedata;
    rd_n    = avm_reg_read;
    wr_n    = avm_reg_write;
    ferr_n  = 1'b0;
    bto_n   = 1'b0;
    unique case (state)
      IDLE: begin
        if (sle) begin
          rx_n = {rx[63:0], sdi};
          if (len != '1) len_n = len + 7'd1;
        end else if (len != '0) begin
          // The don't-care leading bit falls off the top of the 65-bit shifter.
          rx_n  = {rx[63:0], sdi};
          len_n = '0;
          if (len == 7'd65) begin
            state_n = EXEC;
            addr_n  = rx_n[32 +: address_size];
            wdata_n = rx_n[31:0];
            wr_n    = rx_n[64];
            rd_n    = ~rx_n[64];
            wcnt_n  = '0;
          end else begin
            ferr_n = 1'b1;
          end
        end
      end
      EXEC: begin
        if (!avm_reg_waitrequest) begin
          tx_n    = rx[64] ? 32'h0 : avm_reg_readdata;
          rd_n    = 1'b0;
          wr_n    = 1'b0;
          k_n     = '0;
          state_n = RESP;
        end else if (wcnt == WCW'(timeout_cycles - 1)) begin
          tx_n    = '1;
          rd_n    = 1'b0;
          wr_n    = 1'b0;
          bto_n   = 1'b1;
          k_n     = '0;
          state_n = RESP;
        end else begin
          wcnt_n = wcnt + WCW'(1);
        end
      end
      RESP: begin
        if (k == 6'd33) begin
          state_n = IDLE;
          k_n     = '0;
          sdo_n   = 1'b0;
          srdy_n  = 1'b0;
        end else begin
          k_n    = k + 6'd1;
          srdy_n = (k < 6'd32);
          // tx is shifted out MSB first, so cycle k shows original tx[33-k].
          if (k != '0) begin
            sdo_n = tx[31];
            tx_n  = {tx[30:0], 1'b0};
          end else begin
            sdo_n = 1'b0;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_qsys_serial_target.sv
// Bench for qsys_serial_target: serial initiator model, Avalon register-file
// slave with configurable wait states, vector table plus random traffic.
module tb_qsys_serial_target;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        sdi, sle, sdo, srdy;
  logic [7:0]  avm_addr;
  logic [31:0] avm_wdata, avm_rdata;
  logic [3:0]  avm_be;
  logic        avm_wr, avm_rd, avm_wreq;
  logic        frame_err, bus_timeout;

  qsys_serial_target #(.address_size(8), .timeout_cycles(256)) dut (
    .csi_MCLK_clk        (clk),
    .rsi_MRST_reset_n    (rst_n),
    .sdi                 (sdi),
    .sle                 (sle),
    .sdo                 (sdo),
    .srdy                (srdy),
    .avm_reg_address     (avm_addr),
    .avm_reg_writedata   (avm_wdata),
    .avm_reg_byteenable  (avm_be),
    .avm_reg_write       (avm_wr),
    .avm_reg_read        (avm_rd),
    .avm_reg_readdata    (avm_rdata),
    .avm_reg_waitrequest (avm_wreq),
    .frame_err           (frame_err),
    .bus_timeout         (bus_timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          rw;
    logic [31:0] addr;
    logic [31:0] data;
    int unsigned ws;
    bit          stuck;
    int unsigned nhigh;
    bit          exp_err;
    logic [31:0] exp_resp;
  } vec_t;

  typedef struct {
    bit          rw;
    logic [31:0] addr;
    logic [31:0] data;
  } acc_t;

  int          n_chk = 0, n_fail = 0;
  int unsigned ws_cfg = 0;
  bit          stuck_cfg = 1'b0;
  acc_t        acc_q[$];
  logic [31:0] exp_q[$];
  logic [31:0] mem[256];
  logic [31:0] shadow[256];
  int unsigned req_len = 0, last_req_len = 0, cyc = 0;
  int unsigned acc_done = 0, fe_cnt = 0, to_cnt = 0;
  acc_t        sl_e;
  vec_t        vt[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Avalon slave: register file with ws_cfg wait states, or stuck waitrequest.
  always @(negedge clk) begin
    if (avm_rd || avm_wr) begin
      req_len++;
      if (stuck_cfg) begin
        avm_wreq = 1'b1;
      end else if (cyc < ws_cfg) begin
        avm_wreq = 1'b1;
        cyc++;
      end else begin
        avm_wreq = 1'b0;
        cyc = 0;
        acc_done++;
        if (acc_q.size() == 0) begin
          chk("unexpected_access", 32'd1, 32'd0);
        end else begin
          sl_e = acc_q.pop_front();
          chk("acc_write_flag", {31'b0, avm_wr}, {31'b0, sl_e.rw});
          chk("acc_read_flag", {31'b0, avm_rd}, {31'b0, !sl_e.rw});
          chk("acc_addr", {24'b0, avm_addr}, {24'b0, sl_e.addr[7:0]});
          chk("acc_wdata", avm_wdata, sl_e.data);
        end
        if (avm_wr) mem[avm_addr] = avm_wdata;
        else        avm_rdata = mem[avm_addr];
      end
    end else begin
      if (req_len != 0) begin
        last_req_len = req_len;
        req_len = 0;
      end
      avm_wreq = stuck_cfg;
      cyc = 0;
    end
  end

  always @(negedge clk) begin
    if (frame_err)   fe_cnt++;
    if (bus_timeout) to_cnt++;
  end

  task automatic send_frame(input bit rw, input logic [31:0] a, input logic [31:0] d,
                            input int unsigned nhigh);
    logic [64:0] f;
    f = {rw, a, d};
    if (nhigh == 65) begin
      @(negedge clk); sle = 1'b1; sdi = 1'($urandom_range(0, 1));
      for (int i = 64; i >= 1; i--) begin
        @(negedge clk); sdi = f[i];
      end
      @(negedge clk); sle = 1'b0; sdi = f[0];
    end else begin
      for (int i = 0; i < int'(nhigh); i++) begin
        @(negedge clk); sle = 1'b1; sdi = 1'($urandom_range(0, 1));
      end
      @(negedge clk); sle = 1'b0; sdi = 1'b0;
    end
  endtask

  task automatic collect(input vec_t v, input int unsigned fe0, input int unsigned to0);
    bit          got;
    int          lat, bad;
    logic [31:0] word, exp;
    got = 1'b0; lat = 0; bad = 0; word = '0;
    for (int n = 1; n <= 400; n++) begin
      @(negedge clk);
      if (srdy) begin
        got = 1'b1;
        lat = n - 1;
        break;
      end
    end
    chk("srdy_seen", {31'b0, got}, 32'd1);
    exp = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hx;
    if (got) begin
      chk("srdy_latency", lat, v.stuck ? 32'd257 : v.ws + 2);
      chk("sdo_k1_zero", {31'b0, sdo}, 32'd0);
      for (int i = 31; i >= 0; i--) begin
        @(negedge clk);
        word[i] = sdo;
        if (srdy !== (i > 0)) bad++;
      end
      chk("srdy_window", bad, 0);
      @(negedge clk);
      chk("idle_after_resp", {30'b0, srdy, sdo}, 32'd0);
      chk("resp_data", word, exp);
      chk("bus_timeout_pulses", to_cnt - to0, {31'b0, v.stuck});
      chk("req_held_cycles", last_req_len, v.stuck ? 32'd256 : v.ws + 1);
      chk("no_frame_err", fe_cnt - fe0, 32'd0);
    end
  endtask

  task automatic run_vec(input vec_t v);
    int unsigned fe0, to0, a0;
    bit          seen;
    acc_t        e;
    fe0 = fe_cnt; to0 = to_cnt; a0 = acc_done;
    ws_cfg = v.ws;
    stuck_cfg = v.stuck;
    if (!v.exp_err) begin
      exp_q.push_back(v.exp_resp);
      if (!v.stuck) begin
        e.rw = v.rw; e.addr = v.addr; e.data = v.data;
        acc_q.push_back(e);
      end
    end
    send_frame(v.rw, v.addr, v.data, v.nhigh);
    if (v.exp_err) begin
      seen = 1'b0;
      for (int i = 0; i < 12; i++) begin
        @(negedge clk);
        if (srdy || avm_rd || avm_wr) seen = 1'b1;
      end
      chk("bad_frame_quiet", {31'b0, seen}, 32'd0);
      chk("frame_err_pulse", fe_cnt - fe0, 32'd1);
      chk("bad_frame_no_access", acc_done - a0, 32'd0);
    end else begin
      collect(v, fe0, to0);
    end
    stuck_cfg = 1'b0;
    if (v.rw && !v.exp_err && !v.stuck) shadow[v.addr[7:0]] = v.data;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t        rv;
    acc_t        e;
    bit          got;
    rst_n = 1'b0; sle = 1'b0; sdi = 1'b0; avm_wreq = 1'b0; avm_rdata = '0;
    for (int i = 0; i < 256; i++) begin
      mem[i] = '0;
      shadow[i] = '0;
    end
    mem[8'h34] = 32'hA5A5_3C3C;
    shadow[8'h34] = 32'hA5A5_3C3C;

    repeat (3) @(negedge clk);
    chk("rst_outputs", {26'b0, sdo, srdy, avm_rd, avm_wr, frame_err, bus_timeout}, 32'd0);
    chk("rst_address", {24'b0, avm_addr}, 32'd0);
    chk("rst_writedata", avm_wdata, 32'd0);
    chk("byteenable", {28'b0, avm_be}, 32'hF);
    rst_n = 1'b1;

    //         rw    addr           data           ws stuck nhigh err  resp
    vt[0] = '{1'b1, 32'h0000_0012, 32'hCAFE_0001, 0, 1'b0, 65, 1'b0, 32'h0000_0000};
    vt[1] = '{1'b0, 32'h0000_0034, 32'h0,         3, 1'b0, 65, 1'b0, 32'hA5A5_3C3C};
    vt[2] = '{1'b0, 32'h0000_0034, 32'h0,         0, 1'b1, 65, 1'b0, 32'hFFFF_FFFF};
    vt[3] = '{1'b0, 32'h0,         32'h0,         0, 1'b0, 40, 1'b1, 32'h0};
    vt[4] = '{1'b0, 32'h0000_0012, 32'h0,         1, 1'b0, 65, 1'b0, 32'hCAFE_0001};
    vt[5] = '{1'b0, 32'h0,         32'h0,         0, 1'b0, 64, 1'b1, 32'h0};
    vt[6] = '{1'b0, 32'h0,         32'h0,         0, 1'b0, 66, 1'b1, 32'h0};
    vt[7] = '{1'b1, 32'hABCD_01FF, 32'h1234_5678, 2, 1'b0, 65, 1'b0, 32'h0000_0000};
    vt[8] = '{1'b0, 32'h0000_00FF, 32'h0,         0, 1'b0, 65, 1'b0, 32'h1234_5678};
    vt[9] = '{1'b0, 32'h0000_0034, 32'h0,         0, 1'b0, 65, 1'b0, 32'hA5A5_3C3C};
    for (int i = 0; i < 10; i++) run_vec(vt[i]);

    // Reset during the response, at k=10 where sdo carries tx[23]=1.
    ws_cfg = 0;
    e.rw = 1'b0; e.addr = 32'h34; e.data = 32'h0;
    acc_q.push_back(e);
    send_frame(1'b0, 32'h34, 32'h0, 65);
    got = 1'b0;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (srdy) begin
        got = 1'b1;
        break;
      end
    end
    chk("reset_case_srdy_seen", {31'b0, got}, 32'd1);
    repeat (9) @(negedge clk);
    chk("pre_reset_k10", {30'b0, srdy, sdo}, 32'd3);
    #2 rst_n = 1'b0;
    #1 chk("reset_mid_resp", {28'b0, srdy, sdo, avm_rd, avm_wr}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    rv = '{1'b0, 32'h0000_0034, 32'h0, 0, 1'b0, 65, 1'b0, 32'hA5A5_3C3C};
    run_vec(rv);

    for (int i = 0; i < 100; i++) begin
      rv.rw      = 1'($urandom_range(0, 1));
      rv.addr    = $urandom;
      rv.data    = rv.rw ? $urandom : 32'h0;
      rv.ws      = $urandom_range(0, 3);
      rv.stuck   = 1'b0;
      rv.nhigh   = 65;
      rv.exp_err = 1'b0;
      rv.exp_resp = rv.rw ? 32'h0 : shadow[rv.addr[7:0]];
      run_vec(rv);
    end

    chk("scoreboard_drained", exp_q.size() + acc_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
